// File: rtl/regfile_issue_sched.sv
// ---------------------------------------------------------------------------
// regfile_issue_sched
//
// Purpose
//   Request scheduler placed in front of a 32x1W2R register file. It buffers
//   one write channel and two read channels in small FIFOs and issues their
//   heads to the register file. It never issues a colliding combination in
//   the same cycle (W/R1, W/R2 or R1/R2 on the same address). A read that
//   keeps losing to same-address writes eventually wins, after STALL_MAX
//   deferrals. Read data comes back with a valid strobe that is aligned to
//   the register file's one-cycle registered output.
//
// Ports
//   clk, resetn          clock (rising edge), synchronous active-low reset
//   wr_valid/ready/addr/data      write request channel
//   rd1_valid/ready/addr          read channel 1 request
//   rd2_valid/ready/addr          read channel 2 request
//   rf_din, rf_wad1, rf_rad1, rf_rad2, rf_wen1, rf_ren1, rf_ren2
//                        registered issue bus to the register file
//   rf_dout1, rf_dout2, rf_collision    register file outputs
//   rsp1_valid/data, rsp2_valid/data    read responses (no backpressure)
//   sched_err            sticky flag: rf_collision was seen high
//
// Configuration
//   MERGE_RD_EN  when defined, R1 and R2 heads with equal addresses are served
//                by a single rf_ren1 and both responses return together.
//                When undefined, R2 simply waits a cycle in that case.
// ---------------------------------------------------------------------------

// Simple synchronous FIFO with a registered "not full" ready flag.
module regfile_issue_sched_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             ready,
  output logic             not_empty,
  output logic [WIDTH-1:0] head
);
  localparam int PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic             accept;

  // ready is the registered !full, so a full FIFO refuses a push even in a
  // cycle where its head is being popped.
  assign accept    = push && ready;
  assign not_empty = (count_reg != '0);
  assign head      = mem[rd_ptr_reg];

  always_comb begin
    count_next = count_reg;
    if (accept && !pop) begin
      count_next = count_reg + 1'b1;
    end else if (!accept && pop) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ready      <= 1'b0;
    end else begin
      if (accept) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_next;
      ready     <= (count_next != CNT_W'(DEPTH));
    end
  end
endmodule

module regfile_issue_sched #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4,
  parameter int STALL_MAX  = 3
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [4:0]            wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd1_valid,
  output logic                  rd1_ready,
  input  logic [4:0]            rd1_addr,
  input  logic                  rd2_valid,
  output logic                  rd2_ready,
  input  logic [4:0]            rd2_addr,
  output logic [DATA_WIDTH-1:0] rf_din,
  output logic [4:0]            rf_wad1,
  output logic [4:0]            rf_rad1,
  output logic [4:0]            rf_rad2,
  output logic                  rf_wen1,
  output logic                  rf_ren1,
  output logic                  rf_ren2,
  input  logic [DATA_WIDTH-1:0] rf_dout1,
  input  logic [DATA_WIDTH-1:0] rf_dout2,
  input  logic                  rf_collision,
  output logic                  rsp1_valid,
  output logic [DATA_WIDTH-1:0] rsp1_data,
  output logic                  rsp2_valid,
  output logic [DATA_WIDTH-1:0] rsp2_data,
  output logic                  sched_err
);
  localparam int STALL_W = (STALL_MAX < 2) ? 1 : $clog2(STALL_MAX + 1);

  // Write channel
  logic                  w_ne;
  logic [4:0]            w_addr_h;
  logic [DATA_WIDTH-1:0] w_data_h;
  logic                  w_sel;
  logic                  w_blocked;

  // Read channels, index 0 = rd1, index 1 = rd2
  logic [1:0]            rd_valid_vec;
  logic [1:0][4:0]       rd_addr_vec;
  logic [1:0]            rd_ready_vec;
  logic [1:0]            rd_ne;
  logic [1:0][4:0]       rd_head;
  logic [1:0]            rd_pop;
  logic [1:0]            stall_max;
  logic                  r1_sel;
  logic                  r2_sel;
  logic                  r2_hit_r1;
`ifdef MERGE_RD_EN
  logic                  merge;
  logic                  merge_rf_reg;
  logic                  merge_rsp_reg;
`endif

  assign rd_valid_vec = {rd2_valid, rd1_valid};
  assign rd_addr_vec  = {rd2_addr, rd1_addr};
  assign rd1_ready    = rd_ready_vec[0];
  assign rd2_ready    = rd_ready_vec[1];

  regfile_issue_sched_fifo #(
    .WIDTH(5 + DATA_WIDTH),
    .DEPTH(DEPTH)
  ) u_wr_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (wr_valid),
    .push_data({wr_addr, wr_data}),
    .pop      (w_sel),
    .ready    (wr_ready),
    .not_empty(w_ne),
    .head     ({w_addr_h, w_data_h})
  );

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [STALL_W-1:0] stall_reg;

    regfile_issue_sched_fifo #(
      .WIDTH(5),
      .DEPTH(DEPTH)
    ) u_rd_fifo (
      .clk      (clk),
      .resetn   (resetn),
      .push     (rd_valid_vec[gi]),
      .push_data(rd_addr_vec[gi]),
      .pop      (rd_pop[gi]),
      .ready    (rd_ready_vec[gi]),
      .not_empty(rd_ne[gi]),
      .head     (rd_head[gi])
    );

    // Counts consecutive cycles the current head was passed over; the
    // count belongs to the head, so it restarts whenever the head issues.
    always_ff @(posedge clk) begin
      if (!resetn) begin
        stall_reg <= '0;
      end else if (rd_pop[gi]) begin
        stall_reg <= '0;
      end else if (rd_ne[gi] && (stall_reg != STALL_W'(STALL_MAX))) begin
        stall_reg <= stall_reg + 1'b1;
      end
    end

    assign stall_max[gi] = (stall_reg == STALL_W'(STALL_MAX));
  end

  // Priority: W, then R1, then R2 -- except that a starved read on the
  // write's address takes the cycle away from W so it cannot be locked out.
  always_comb begin
    w_blocked = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (rd_ne[i] && stall_max[i] && (rd_head[i] == w_addr_h)) begin
        w_blocked = 1'b1;
      end
    end
    w_sel     = w_ne && !w_blocked;
    r1_sel    = rd_ne[0] && !(w_sel && (rd_head[0] == w_addr_h));
    r2_hit_r1 = r1_sel && (rd_head[1] == rd_head[0]);
    r2_sel    = rd_ne[1] && !(w_sel && (rd_head[1] == w_addr_h)) && !r2_hit_r1;
`ifdef MERGE_RD_EN
    // Same address as an issuing R1: ride along on rf_ren1 instead of waiting.
    merge     = rd_ne[1] && r2_hit_r1;
    rd_pop    = {r2_sel || merge, r1_sel};
`else
    rd_pop    = {r2_sel, r1_sel};
`endif
  end

  // Issue bus data fields are only meaningful alongside their enables, so
  // they are left without reset.
  always_ff @(posedge clk) begin
    rf_din  <= w_data_h;
    rf_wad1 <= w_addr_h;
    rf_rad1 <= rd_head[0];
    rf_rad2 <= rd_head[1];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rf_wen1    <= 1'b0;
      rf_ren1    <= 1'b0;
      rf_ren2    <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp2_valid <= 1'b0;
      sched_err  <= 1'b0;
`ifdef MERGE_RD_EN
      merge_rf_reg  <= 1'b0;
      merge_rsp_reg <= 1'b0;
`endif
    end else begin
      rf_wen1    <= w_sel;
      rf_ren1    <= r1_sel;
      rf_ren2    <= r2_sel;
      rsp1_valid <= rf_ren1;
`ifdef MERGE_RD_EN
      merge_rf_reg  <= merge;
      merge_rsp_reg <= merge_rf_reg;
      rsp2_valid    <= rf_ren2 || merge_rf_reg;
`else
      rsp2_valid    <= rf_ren2;
`endif
      if (rf_collision) begin
        sched_err <= 1'b1;
      end
    end
  end

  assign rsp1_data = rf_dout1;
`ifdef MERGE_RD_EN
  // A merged R2 was served through read port 1.
  assign rsp2_data = merge_rsp_reg ? rf_dout1 : rf_dout2;
`else
  assign rsp2_data = rf_dout2;
`endif

endmodule
